// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit holding the architectural HI/LO pair.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   start   in   one-cycle request, sampled with mdu_op/rs_val/rt_val
//   mdu_op  in   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                101 mthi, 110 mtlo, 111 reserved (none)
//   rs_val  in   operand A (multiplicand / dividend / mthi-mtlo source)
//   rt_val  in   operand B (multiplier / divisor)
//   busy    out  registered, high while a mult/div is in flight
//   hi, lo  out  architectural HI/LO registers
//
// Build option
//   MDU_DIV_EN  defined: div/divu implemented. Undefined: the divide
//               datapath is absent and opcodes 011/100 act as none.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepts requests; mthi/mtlo write HI/LO directly
// CALC  | 32 iterations, one multiplier/quotient bit per cycle
// FIX   | sign correction and HI/LO commit

module mdu #(
   parameter int MDU_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mdu_op,
   input  logic [MDU_W-1:0] rs_val,
   input  logic [MDU_W-1:0] rt_val,
   output logic             busy,
   output logic [MDU_W-1:0] hi,
   output logic [MDU_W-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [4:0] CNT_LAST = 5'd31;

   logic [1:0]         state;
   logic [4:0]         cnt;
   logic [2*MDU_W-1:0] acc;
   logic [MDU_W-1:0]   a_mag;
   logic               neg_res;

   logic               op_long;
   logic               op_sgn;
   logic               sign_a;
   logic               sign_b;
   logic [MDU_W-1:0]   a_abs;
   logic [MDU_W-1:0]   b_abs;
   logic [MDU_W:0]     mul_sum;
   logic [2*MDU_W-1:0] mul_next;
   logic [2*MDU_W-1:0] prod_fix;

`ifdef MDU_DIV_EN
   logic               op_isdiv;
   logic               is_div;
   logic               neg_rem;
   logic               div_zero;
   logic [MDU_W-1:0]   b_mag;
   logic [MDU_W:0]     rem_sh;
   logic [MDU_W:0]     trial;
   logic [2*MDU_W-1:0] div_next;
   logic [MDU_W-1:0]   quo_fix;
   logic [MDU_W-1:0]   rem_fix;
`endif

   always_comb begin
      op_sgn = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
`ifdef MDU_DIV_EN
      op_isdiv = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
      op_long  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) || op_isdiv;
`else
      op_long  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`endif
      sign_a = op_sgn & rs_val[MDU_W-1];
      sign_b = op_sgn & rt_val[MDU_W-1];
      a_abs  = sign_a ? -rs_val : rs_val;
      b_abs  = sign_b ? -rt_val : rt_val;
   end

   // Multiply: acc = {partial, remaining multiplier bits}; add into the
   // upper half when the current multiplier LSB is set, then shift right.
   always_comb begin
      mul_sum  = {1'b0, acc[2*MDU_W-1:MDU_W]} + (acc[0] ? {1'b0, a_mag} : '0);
      mul_next = {mul_sum, acc[MDU_W-1:1]};
      prod_fix = neg_res ? -acc : acc;
   end

`ifdef MDU_DIV_EN
   // Restoring divide: acc = {remainder, dividend/quotient}. Shift left one,
   // trial-subtract the divisor, and shift the quotient bit in at the LSB.
   always_comb begin
      rem_sh   = acc[2*MDU_W-1:MDU_W-1];
      trial    = rem_sh - {1'b0, b_mag};
      div_next = trial[MDU_W] ? {rem_sh[MDU_W-1:0], acc[MDU_W-2:0], 1'b0}
                              : {trial[MDU_W-1:0], acc[MDU_W-2:0], 1'b1};
      quo_fix  = neg_res ? -acc[MDU_W-1:0] : acc[MDU_W-1:0];
      rem_fix  = neg_rem ? -acc[2*MDU_W-1:MDU_W] : acc[2*MDU_W-1:MDU_W];
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         acc     <= '0;
         a_mag   <= '0;
         neg_res <= 1'b0;
`ifdef MDU_DIV_EN
         is_div   <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         b_mag    <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (op_long) begin
                     a_mag   <= a_abs;
                     neg_res <= sign_a ^ sign_b;
                     cnt     <= '0;
                     busy    <= 1'b1;
                     state   <= S_CALC;
`ifdef MDU_DIV_EN
                     is_div   <= op_isdiv;
                     neg_rem  <= sign_a;
                     div_zero <= (rt_val == '0);
                     b_mag    <= b_abs;
                     acc      <= op_isdiv ? {{MDU_W{1'b0}}, a_abs}
                                          : {{MDU_W{1'b0}}, b_abs};
`else
                     acc      <= {{MDU_W{1'b0}}, b_abs};
`endif
                  end else if (mdu_op == OP_MTHI) begin
                     hi <= rs_val;
                  end else if (mdu_op == OP_MTLO) begin
                     lo <= rs_val;
                  end
               end
            end
            S_CALC: begin
`ifdef MDU_DIV_EN
               acc <= is_div ? div_next : mul_next;
`else
               acc <= mul_next;
`endif
               cnt <= cnt + 5'd1;
               if (cnt == CNT_LAST) state <= S_FIX;
            end
            S_FIX: begin
`ifdef MDU_DIV_EN
               if (is_div) begin
                  // Divide by zero keeps the previous HI/LO.
                  if (!div_zero) begin
                     lo <= quo_fix;
                     hi <= rem_fix;
                  end
               end else begin
                  hi <= prod_fix[2*MDU_W-1:MDU_W];
                  lo <= prod_fix[MDU_W-1:0];
               end
`else
               hi <= prod_fix[2*MDU_W-1:MDU_W];
               lo <= prod_fix[MDU_W-1:0];
`endif
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
